matrix_scan_controller: RTL and testbench
=========================================

MATRIX_SCAN_CONTROLLER -- requirements
Module: matrix_scan_controller

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 2500, clk cycles per row slot (must exceed BLANK_CYC).
REQ-002 SHALL have parameter BLANK_CYC, default 4, clk cycles per slot with the matrix forced dark (ghosting guard).
REQ-003 SHALL have parameter BLINK_FRAMES, default 64, frames per blink half-period in done state.
REQ-004 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-005 Port `clk`, input, 1 bit: the single clock.
REQ-006 Port `reset`, input, 1 bit: asynchronous reset, active-low.
REQ-007 Port `game_state`, input, 2 bits: 0 p1_serve, 1 p2_serve, 2 playing, 3 done.
REQ-008 Ports `p1_score` and `p2_score`, input, 4 bits each: player scores.
REQ-009 Port `dot_matrix_row`, output, 8 bits: one-hot active-low row select.
REQ-010 Port `dot_matrix_left_col`, output, 8 bits: active-high columns, player 1 panel.
REQ-011 Port `dot_matrix_right_col`, output, 8 bits: active-high columns, player 2 panel.

Function
REQ-012 Prescaler SHALL count 0..SCAN_DIV-1 and wrap; row index r (0..7) SHALL advance on the wrap cycle; r SHALL wrap 7->0.
REQ-013 When prescaler < BLANK_CYC: dot_matrix_row SHALL be 8'hFF and both col buses 8'h00.
REQ-014 Otherwise: dot_matrix_row SHALL be ~(8'b1<<r), and the col buses SHALL carry row r of each panel image.
REQ-015 Shadow registers for game_state, p1_score and p2_score SHALL load on the r 7->0 transition only; mid-frame input changes SHALL become visible at the next frame start.
REQ-016 Panel rows 0..6 SHALL show the glyph of that panel's shadow score: digits 0..9, or glyph 'E' for scores 10..15.
REQ-017 Panel row 7 (status bar) SHALL follow the shadow state:
- p1_serve: left 8'hFF, right 8'h00.
- p2_serve: left 8'h00, right 8'hFF.
- playing: both 8'h00.
- done: winner's panel 8'hFF.
REQ-018 Winner SHALL be the panel with the strictly higher score; on a tie, both panels count as winners.
REQ-019 Frame counter SHALL increment on each r 7->0 transition while the shadow state is done; it SHALL clear whenever the shadow state is not done.
REQ-020 Blink phase SHALL toggle each time the frame counter reaches BLINK_FRAMES-1 (counter then wraps to 0); phase SHALL start at 1 (visible) on entry to done.
REQ-021 Outputs SHALL be registered: one clk latency from prescaler/row state to the pins.
REQ-022 A game_state change while the prescaler is mid-slot SHALL NOT alter the current frame.

Reset
REQ-023 On reset low, immediately:
- dot_matrix_row = 8'hFF; col buses = 8'h00.
- prescaler = 0; r = 0; frame counter = 0; blink phase = 1.
- shadows load state 0 and scores 0.
REQ-024 After reset release, the first row-0 slot SHALL begin with the blank window, and shadows SHALL load on the first clk edge.

Configuration
REQ-025 Feature macro: DONE_BLINK_EN.
- Defined: in done state, the winner's whole panel (rows 0..7) SHALL be forced to 8'h00 while blink phase = 0.
- Undefined: the frame counter and phase logic SHALL be absent, and the done display SHALL be steady.

Structure
REQ-026 Shared package pong_pkg SHALL hold:
- the game_state encodings (P1_SERVE, P2_SERVE, PLAYING, DONE);
- the 11-entry 7x8 glyph table (digits 0..9 plus 'E').
REQ-027 A combinational sub-module glyph_rom (index 4 bits, row 3 bits -> 8-bit cols) SHALL be instantiated twice, once per panel.

Verification (SCAN_DIV=8, BLANK_CYC=2, BLINK_FRAMES=2)
REQ-028 Scan timing. Stimulus: reset, release, run 64 cycles. Response: each row 0..7 driven low once per 8-cycle slot; first 2 cycles of each slot have row = 8'hFF and cols = 0.
REQ-029 Score glyphs. Stimulus: state=playing, p1_score=3, p2_score=12. Response: left rows 0..6 match glyph '3', right rows 0..6 match glyph 'E', row 7 = 8'h00 on both panels.
REQ-030 Frame-boundary update. Stimulus: change p1_score from 2 to 5 while r=3. Response: rows 3..7 of the current frame still show '2'; '5' appears from the next row-0 slot.
REQ-031 Done blink. Stimulus: with DONE_BLINK_EN defined, state=done, scores 7/4. Response: left panel lit 2 frames, dark 2 frames, repeating; right panel steady '4' with row 7 = 0. With the macro undefined: left panel steady.
REQ-032 Async reset mid-slot. Stimulus: state=p2_serve, assert reset at prescaler=5, r=6. Response: outputs FF/00/00 in the same cycle without a clk edge; after release, scan restarts at r=0.

Source files
------------

// File: rtl/pong_pkg.sv
// pong_pkg
// Shared definitions for the pong scoreboard matrix driver:
//   - game_state encodings as driven by the game controller
//   - the 11-entry 7x8 score glyph table (digits 0..9, then 'E')
// Glyph entries pack row 0 in bits [55:48] down to row 6 in bits [7:0];
// within a row, bit 7 is the leftmost column.
// No ports.

package pong_pkg;

    typedef enum logic [1:0] {
        P1_SERVE = 2'd0,
        P2_SERVE = 2'd1,
        PLAYING  = 2'd2,
        DONE     = 2'd3
    } game_state_e;

    localparam int          GLYPH_COUNT = 11;
    localparam logic [3:0]  GLYPH_E     = 4'd10;

    localparam logic [55:0] GLYPH_TAB [GLYPH_COUNT] = '{
        56'h3C_42_46_5A_62_42_3C,   // 0
        56'h18_38_18_18_18_18_3C,   // 1
        56'h3C_42_02_0C_30_40_7E,   // 2
        56'h3C_42_02_1C_02_42_3C,   // 3
        56'h0C_1C_2C_4C_7E_0C_0C,   // 4
        56'h7E_40_7C_02_02_42_3C,   // 5
        56'h1C_20_40_7C_42_42_3C,   // 6
        56'h7E_02_04_08_10_10_10,   // 7
        56'h3C_42_42_3C_42_42_3C,   // 8
        56'h3C_42_42_3E_02_04_38,   // 9
        56'h7E_40_40_7C_40_40_7E    // E (score out of digit range)
    };

    // Scores 10..15 have no single-digit glyph and share the 'E' entry.
    function automatic logic [3:0] glyph_index(input logic [3:0] score);
        return (score > 4'd9) ? GLYPH_E : score;
    endfunction

endpackage

// File: rtl/glyph_rom.sv
// glyph_rom
// Combinational lookup of one row of a score glyph.
// Ports:
//   idx_i  [3:0] score value (10..15 map to the 'E' glyph)
//   row_i  [2:0] glyph row; row 7 is not part of the glyph and reads 0
//   cols_o [7:0] active-high column pattern for that row

module glyph_rom (
    input  logic [3:0] idx_i,
    input  logic [2:0] row_i,
    output logic [7:0] cols_o
);
    import pong_pkg::*;

    logic [55:0] glyph;

    always_comb begin
        glyph  = GLYPH_TAB[glyph_index(idx_i)];
        cols_o = 8'h00;
        case (row_i)
            3'd0:    cols_o = glyph[55:48];
            3'd1:    cols_o = glyph[47:40];
            3'd2:    cols_o = glyph[39:32];
            3'd3:    cols_o = glyph[31:24];
            3'd4:    cols_o = glyph[23:16];
            3'd5:    cols_o = glyph[15:8];
            3'd6:    cols_o = glyph[7:0];
            default: cols_o = 8'h00;
        endcase
    end

endmodule

// File: rtl/matrix_scan_controller.sv
// matrix_scan_controller
// Row-multiplexed driver for two 8x8 LED panels showing the pong score.
// Each row gets a slot of SCAN_DIV clocks; the first BLANK_CYC clocks of a
// slot keep the matrix dark so the previous row cannot ghost into the next.
// Game state and scores are sampled into shadows only at frame start, so a
// frame is always drawn from one consistent snapshot.
// Optional feature macro: DONE_BLINK_EN -- when defined, the winner's panel
// blinks in the done state (BLINK_FRAMES frames on, BLINK_FRAMES off).
// Ports:
//   clk                        system clock
//   reset                      asynchronous reset, active low
//   game_state           [1:0] 0 p1_serve, 1 p2_serve, 2 playing, 3 done
//   p1_score, p2_score   [3:0] player scores
//   dot_matrix_row       [7:0] one-hot active-low row select (registered)
//   dot_matrix_left_col  [7:0] player 1 panel columns, active high (registered)
//   dot_matrix_right_col [7:0] player 2 panel columns, active high (registered)

module matrix_scan_controller #(
    parameter int SCAN_DIV     = 2500,
    parameter int BLANK_CYC    = 4,
    parameter int BLINK_FRAMES = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] game_state,
    input  logic [3:0] p1_score,
    input  logic [3:0] p2_score,
    output logic [7:0] dot_matrix_row,
    output logic [7:0] dot_matrix_left_col,
    output logic [7:0] dot_matrix_right_col
);
    import pong_pkg::*;

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [PW-1:0] presc_q, presc_d;
    logic [2:0]    row_q, row_d;
    logic          first_q;
    game_state_e   state_sh_q;
    logic [3:0]    p1_sh_q, p2_sh_q;

    logic          slot_end;
    logic          frame_end;
    logic          shadow_load;
    logic          p1_win, p2_win;
    logic          blink_on;
    logic [7:0]    left_glyph, right_glyph;
    logic [7:0]    row_pins_d, left_d, right_d;
    logic [7:0]    row_pins_q, left_q, right_q;

    assign slot_end    = (presc_q == PW'(SCAN_DIV - 1));
    assign frame_end   = slot_end && (row_q == 3'd7);
    // The first edge after reset release also loads, so frame 0 shows live inputs.
    assign shadow_load = first_q || frame_end;

    always_comb begin
        presc_d = slot_end ? '0 : presc_q + 1'b1;
        row_d   = slot_end ? row_q + 3'd1 : row_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_q    <= '0;
            row_q      <= 3'd0;
            first_q    <= 1'b1;
            state_sh_q <= P1_SERVE;
            p1_sh_q    <= 4'd0;
            p2_sh_q    <= 4'd0;
        end else begin
            presc_q <= presc_d;
            row_q   <= row_d;
            first_q <= 1'b0;
            if (shadow_load) begin
                state_sh_q <= game_state_e'(game_state);
                p1_sh_q    <= p1_score;
                p2_sh_q    <= p2_score;
            end
        end
    end

    glyph_rom u_glyph_left (
        .idx_i  (p1_sh_q),
        .row_i  (row_q),
        .cols_o (left_glyph)
    );

    glyph_rom u_glyph_right (
        .idx_i  (p2_sh_q),
        .row_i  (row_q),
        .cols_o (right_glyph)
    );

    // A tie lights both panels.
    assign p1_win = (p1_sh_q >= p2_sh_q);
    assign p2_win = (p2_sh_q >= p1_sh_q);

`ifdef DONE_BLINK_EN
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [FW-1:0] frame_cnt_q, frame_cnt_d;
    logic          blink_q, blink_d;

    // Counting uses the outgoing frame's state, so the first done frame
    // always starts visible with the counter at zero.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        blink_d     = blink_q;
        if (state_sh_q != DONE) begin
            frame_cnt_d = '0;
            blink_d     = 1'b1;
        end else if (frame_end) begin
            if (frame_cnt_q == FW'(BLINK_FRAMES - 1)) begin
                frame_cnt_d = '0;
                blink_d     = ~blink_q;
            end else begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_cnt_q <= '0;
            blink_q     <= 1'b1;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            blink_q     <= blink_d;
        end
    end

    assign blink_on = blink_q;
`else
    logic unused_blink_cfg;
    assign unused_blink_cfg = ^BLINK_FRAMES;
    assign blink_on         = 1'b1;
`endif

    always_comb begin
        row_pins_d = 8'hFF;
        left_d     = 8'h00;
        right_d    = 8'h00;
        if (presc_q >= PW'(BLANK_CYC)) begin
            row_pins_d = ~(8'b1 << row_q);
            if (row_q != 3'd7) begin
                left_d  = left_glyph;
                right_d = right_glyph;
            end else begin
                case (state_sh_q)
                    P1_SERVE: left_d  = 8'hFF;
                    P2_SERVE: right_d = 8'hFF;
                    PLAYING:  ;
                    DONE: begin
                        left_d  = p1_win ? 8'hFF : 8'h00;
                        right_d = p2_win ? 8'hFF : 8'h00;
                    end
                    default: ;
                endcase
            end
            if ((state_sh_q == DONE) && !blink_on) begin
                if (p1_win) left_d  = 8'h00;
                if (p2_win) right_d = 8'h00;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_pins_q <= 8'hFF;
            left_q     <= 8'h00;
            right_q    <= 8'h00;
        end else begin
            row_pins_q <= row_pins_d;
            left_q     <= left_d;
            right_q    <= right_d;
        end
    end

    assign dot_matrix_row       = row_pins_q;
    assign dot_matrix_left_col  = left_q;
    assign dot_matrix_right_col = right_q;

endmodule

// File: tb/tb_matrix_scan_controller.sv
// tb_matrix_scan_controller
// Self-checking bench for matrix_scan_controller with SCAN_DIV=8,
// BLANK_CYC=2, BLINK_FRAMES=2. The expected pins for every clock are derived
// from the edge count since reset release and a per-frame input snapshot.

module tb_matrix_scan_controller;

    localparam int SD    = 8;
    localparam int BC    = 2;
    localparam int BF    = 2;
    localparam int FRAME = SD * 8;

    logic       clk;
    logic       reset;
    logic [1:0] game_state;
    logic [3:0] p1_score;
    logic [3:0] p2_score;
    logic [7:0] row_pins;
    logic [7:0] left_cols;
    logic [7:0] right_cols;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int n;          // clock edges since reset release
    int m_state;
    int m_p1;
    int m_p2;
    int m_k;        // frames spent in done so far (0 on the first done frame)

    matrix_scan_controller #(
        .SCAN_DIV     (SD),
        .BLANK_CYC    (BC),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .game_state           (game_state),
        .p1_score             (p1_score),
        .p2_score             (p2_score),
        .dot_matrix_row       (row_pins),
        .dot_matrix_left_col  (left_cols),
        .dot_matrix_right_col (right_cols)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: observed %h expected %h (edge %0d)", tag, got, exp, n);
        end
    endtask

    function automatic logic [7:0] font_row(input int score, input int row);
        logic [55:0] g;
        int idx;
        idx = (score > 9) ? 10 : score;
        case (idx)
            0:       g = 56'h3C_42_46_5A_62_42_3C;
            1:       g = 56'h18_38_18_18_18_18_3C;
            2:       g = 56'h3C_42_02_0C_30_40_7E;
            3:       g = 56'h3C_42_02_1C_02_42_3C;
            4:       g = 56'h0C_1C_2C_4C_7E_0C_0C;
            5:       g = 56'h7E_40_7C_02_02_42_3C;
            6:       g = 56'h1C_20_40_7C_42_42_3C;
            7:       g = 56'h7E_02_04_08_10_10_10;
            8:       g = 56'h3C_42_42_3C_42_42_3C;
            9:       g = 56'h3C_42_42_3E_02_04_38;
            default: g = 56'h7E_40_40_7C_40_40_7E;
        endcase
        return g[8*(6-row) +: 8];
    endfunction

    // Pins expected while the given scan slot (clock index since release) is shown.
    function automatic logic [23:0] model_pins(input int slot);
        int presc;
        int r;
        bit w1, w2, vis;
        logic [7:0] l, rt;
        presc = slot % SD;
        r     = (slot / SD) % 8;
        if (presc < BC) return 24'hFF_00_00;
        w1 = (m_p1 >= m_p2);
        w2 = (m_p2 >= m_p1);
`ifdef DONE_BLINK_EN
        vis = ((m_k / BF) % 2) == 0;
`else
        vis = 1'b1;
`endif
        l  = 8'h00;
        rt = 8'h00;
        if (r < 7) begin
            l  = font_row(m_p1, r);
            rt = font_row(m_p2, r);
        end else begin
            case (m_state)
                0: l  = 8'hFF;
                1: rt = 8'hFF;
                3: begin
                    l  = w1 ? 8'hFF : 8'h00;
                    rt = w2 ? 8'hFF : 8'h00;
                end
                default: ;
            endcase
        end
        if (m_state == 3 && !vis) begin
            if (w1) l  = 8'h00;
            if (w2) rt = 8'h00;
        end
        return {~(8'd1 << r), l, rt};
    endfunction

    task automatic model_reset();
        n       = 0;
        m_state = 0;
        m_p1    = 0;
        m_p2    = 0;
        m_k     = 0;
    endtask

    task automatic step(input string tag);
        logic [23:0] exp;
        @(posedge clk);
        n++;
        exp = model_pins(n - 1);
        if (n == 1 || (n % FRAME) == 0) begin
            if (game_state == 2'd3 && m_state == 3) m_k++;
            else m_k = 0;
            m_state = int'(game_state);
            m_p1    = int'(p1_score);
            m_p2    = int'(p2_score);
        end
        #1;
        check(tag, {8'h00, row_pins, left_cols, right_cols}, {8'h00, exp});
    endtask

    task automatic run(input int cycles, input string tag);
        for (int i = 0; i < cycles; i++) step(tag);
    endtask

    // Step until the scan position (edges mod frame length) hits target; bounded.
    task automatic run_until(input int target, input string tag);
        for (int g = 0; g < 2 * FRAME; g++) begin
            if ((n % FRAME) == target) break;
            step(tag);
        end
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        game_state = 2'd2;
        p1_score   = 4'd3;
        p2_score   = 4'd12;
        reset      = 1'b1;
        #1 reset   = 1'b0;
        #2;
        check("reset_pins", {8'h00, row_pins, left_cols, right_cols}, 32'h00FF_0000);
        repeat (3) @(posedge clk);
        #1;
        check("reset_hold", {8'h00, row_pins, left_cols, right_cols}, 32'h00FF_0000);

        @(negedge clk);
        reset = 1'b1;
        model_reset();

        // Scan timing and glyphs: playing, 3 vs 12
        run(2 * FRAME, "scan_playing");

        // Serve indicators
        game_state = 2'd0; p1_score = 4'd0; p2_score = 4'd9;
        run(2 * FRAME, "p1_serve");
        game_state = 2'd1; p1_score = 4'd10; p2_score = 4'd1;
        run(2 * FRAME, "p2_serve");

        // Done with player 1 winning 7:4, long enough to see several blink periods
        game_state = 2'd3; p1_score = 4'd7; p2_score = 4'd4;
        run(9 * FRAME, "done_p1");
        // Tie: both panels are winners
        p1_score = 4'd6; p2_score = 4'd6;
        run(5 * FRAME, "done_tie");
        // Player 2 wins
        p1_score = 4'd2; p2_score = 4'd11;
        run(5 * FRAME, "done_p2");

        // Mid-frame change: p1 goes 2 -> 5 during row 3; visible only next frame
        game_state = 2'd2; p1_score = 4'd2; p2_score = 4'd8;
        run_until(0, "fb_align");
        run_until(3 * SD + 4, "fb_pre");
        p1_score = 4'd5;
        run(2 * FRAME, "frame_boundary");

        // Mid-slot state change must not disturb the current frame
        run_until(2 * SD + 3, "mid_slot_align");
        game_state = 2'd3;
        run(2 * FRAME, "mid_slot_state");

        // Randomized input activity
        for (int i = 0; i < 25 * FRAME; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                case ($urandom_range(0, 2))
                    0:       game_state = 2'($urandom_range(0, 3));
                    1:       p1_score   = 4'($urandom_range(0, 15));
                    default: p2_score   = 4'($urandom_range(0, 15));
                endcase
            end
            step("random");
        end

        // Asynchronous reset mid-slot: prescaler 5, row 6, p2_serve
        game_state = 2'd1; p1_score = 4'd4; p2_score = 4'd5;
        run(FRAME, "pre_async");
        run_until(6 * SD + 5, "async_align");
        #2 reset = 1'b0;
        #1;
        check("async_reset_pins", {8'h00, row_pins, left_cols, right_cols}, 32'h00FF_0000);
        repeat (2) @(posedge clk);
        #1;
        check("async_reset_hold", {8'h00, row_pins, left_cols, right_cols}, 32'h00FF_0000);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        run(2 * FRAME, "restart");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
